// File: rtl/stall_seq_pkg.sv
// stall_seq_pkg: shared definitions for the stall sequencer.
//   state_t  : sequencer state (idle / holding the pipeline)
//   MIN_LEN  : shortest hold ever issued; a requested length of 0 becomes this
//   PERF_W   : width of the optional stall-cycle performance counter
package stall_seq_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  localparam int MIN_LEN = 1;
  localparam int PERF_W  = 16;

endpackage

// File: rtl/stall_sequencer_hold_timer.sv
// hold_timer: loadable down-counter that times one pipeline hold.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : load len into the counter this cycle (takes priority over counting)
//   len      : hold length to load, already clamped to >= MIN_LEN by the caller
//   active   : a hold is in progress (counter non-zero)
//   last     : this is the final cycle of the hold (counter == MIN_LEN)
module hold_timer
  import stall_seq_pkg::*;
#(
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  output logic             active,
  output logic             last
);

  logic [LEN_W-1:0] cnt_reg;

  // A load on the final cycle chains straight into the next hold, so the
  // counter never passes through zero between back-to-back grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= len;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign active = (cnt_reg != '0);
  assign last   = (cnt_reg == LEN_W'(MIN_LEN));

endmodule

// File: rtl/stall_sequencer.sv
// stall_sequencer: round-robin arbiter that shares one multi-cycle pipeline
// hold between several hazard sources.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   req          : level request per requester, held until its done
//   req_len      : hold length per requester, slice i = [i*LEN_W +: LEN_W]
//   grant        : one-hot, requester currently being served
//   done         : one-cycle pulse on the final hold cycle of the served requester
//   stall_en     : pipeline hold, high while any grant is active
//   busy         : copy of stall_en for the hazard unit
//   stall_cycles : saturating count of stall cycles (only with STALL_SEQ_PERF_EN)
// Build option: define STALL_SEQ_PERF_EN to add the stall_cycles counter/port.
module stall_sequencer
  import stall_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     stall_en,
  output logic                     busy
`ifdef STALL_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]        stall_cycles
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;

  logic [LEN_W-1:0]   len_eff [NUM_REQ];
  logic [PTR_W-1:0]   rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   win_ptr;

  logic               timer_load;
  logic               timer_active;
  logic               timer_last;

  // Per requester: its position in the rotated search order starting at ptr,
  // and its effective hold length (0 clamped up to MIN_LEN).
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [PTR_W:0] rot_sum;
      assign rot_sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
      assign rot_idx[gi] = (rot_sum >= (PTR_W+1)'(NUM_REQ))
                         ? PTR_W'(rot_sum - (PTR_W+1)'(NUM_REQ))
                         : PTR_W'(rot_sum);
      assign len_eff[gi] = (req_len[gi*LEN_W +: LEN_W] == '0)
                         ? LEN_W'(MIN_LEN)
                         : req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // The requester finishing this cycle still has req high; masking with the
  // current grant keeps it from winning again before the others. In IDLE the
  // grant is zero so nothing is masked.
  assign cand = req & ~grant_reg;

  // Scan from the far end so the lowest rotated position wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand[rot_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = rot_idx[k];
      end
    end
  end

  assign win_onehot = NUM_REQ'(1) << win_idx;
  assign win_ptr    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    timer_load = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          state_next = ST_HOLD;
          grant_next = win_onehot;
          ptr_next   = win_ptr;
          timer_load = 1'b1;
        end
      end
      ST_HOLD: begin
        // Arbitrate on the final cycle so the next hold starts without a bubble.
        if (timer_last) begin
          if (win_found) begin
            grant_next = win_onehot;
            ptr_next   = win_ptr;
            timer_load = 1'b1;
          end else begin
            state_next = ST_IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  hold_timer #(
    .LEN_W (LEN_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .len    (len_eff[win_idx]),
    .active (timer_active),
    .last   (timer_last)
  );

  assign grant    = grant_reg;
  assign done     = grant_reg & {NUM_REQ{timer_last}};
  assign stall_en = timer_active;
  assign busy     = timer_active;

`ifdef STALL_SEQ_PERF_EN
  logic [PERF_W-1:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (timer_active && (stall_cycles_reg != '1)) begin
      stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_stall_sequencer.sv
// tb_stall_sequencer: directed and protocol-respecting random stimulus for
// stall_sequencer, with a per-cycle reference model and literal spot checks.
module tb_stall_sequencer;

  localparam int NREQ = 4;
  localparam int LW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              stall_en;
  logic              busy;
`ifdef STALL_SEQ_PERF_EN
  logic [15:0]       stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Reference model: who is being served, how many hold cycles remain
  // (including the current one), and where the round-robin search starts.
  int m_cur  = -1;
  int m_rem  = 0;
  int m_ptr  = 0;
  int m_perf = 0;

  stall_sequencer #(
    .NUM_REQ (NREQ),
    .LEN_W   (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_len  (req_len),
    .grant    (grant),
    .done     (done),
    .stall_en (stall_en),
    .busy     (busy)
`ifdef STALL_SEQ_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Model update on each edge, then compare #1 later once the DUT has settled.
  always @(posedge clk) begin
    int w;
    int idx;
    int l;
    bit was_active;
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] exp_done;

    cycle++;
    was_active = (m_cur >= 0);
    if (rst) begin
      m_cur  = -1;
      m_rem  = 0;
      m_ptr  = 0;
      m_perf = 0;
    end else begin
      if (was_active && m_perf < 65535) m_perf++;
      if (was_active && m_rem > 1) begin
        m_rem--;
      end else begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req[idx] && idx != m_cur) w = idx;
        end
        if (w >= 0) begin
          l     = int'(req_len[w*LW +: LW]);
          m_cur = w;
          m_rem = (l == 0) ? 1 : l;
          m_ptr = (w + 1) % NREQ;
        end else begin
          m_cur = -1;
          m_rem = 0;
        end
      end
    end

    #1;
    exp_grant = (m_cur >= 0) ? (NREQ'(1) << m_cur) : '0;
    exp_done  = (m_cur >= 0 && m_rem == 1) ? exp_grant : '0;
    chk("model_grant", grant, exp_grant);
    chk("model_done", done, exp_done);
    chk("model_stall_en", stall_en, m_cur >= 0);
    chk("model_busy", busy, m_cur >= 0);
`ifdef STALL_SEQ_PERF_EN
    chk("model_stall_cycles", stall_cycles, m_perf);
`endif
    if (exp_done != '0)
      $display("txn: cycle %0d requester %0d done, next ptr %0d", cycle, m_cur, m_ptr);
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_len = '0;
    step();
    step();
    chk("reset_grant", grant, 4'b0000);
    chk("reset_done", done, 4'b0000);
    chk("reset_stall_en", stall_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // Single request, length 2 on requester 1.
    req     = 4'b0010;
    req_len = {3'd0, 3'd0, 3'd2, 3'd0};
    step();
    chk("single_c1_grant", grant, 4'b0010);
    chk("single_c1_stall", stall_en, 1'b1);
    chk("single_c1_done", done, 4'b0000);
    step();
    chk("single_c2_grant", grant, 4'b0010);
    chk("single_c2_done", done, 4'b0010);
    req = 4'b0000;
    step();
    chk("single_idle_grant", grant, 4'b0000);
    chk("single_idle_stall", stall_en, 1'b0);

    // Simultaneous requests 0,1,3 of length 1 from ptr 0.
    rst = 1'b1;
    step();
    rst     = 1'b0;
    req     = 4'b1011;
    req_len = {3'd1, 3'd1, 3'd1, 3'd1};
    step();
    chk("simul_c1_grant", grant, 4'b0001);
    chk("simul_c1_done", done, 4'b0001);
    req = 4'b1010;
    step();
    chk("simul_c2_grant", grant, 4'b0010);
    chk("simul_c2_stall", stall_en, 1'b1);
    req = 4'b1000;
    step();
    chk("simul_c3_grant", grant, 4'b1000);
    chk("simul_c3_done", done, 4'b1000);
    req = 4'b0000;
    step();
    chk("simul_idle_stall", stall_en, 1'b0);

    // Back-to-back: req 0 length 3 then req 2 length 2, no bubble.
    req     = 4'b0101;
    req_len = {3'd0, 3'd2, 3'd0, 3'd3};
    step();
    chk("b2b_c1_grant", grant, 4'b0001);
    step();
    chk("b2b_c2_done", done, 4'b0000);
    step();
    chk("b2b_c3_done", done, 4'b0001);
    req = 4'b0100;
    step();
    chk("b2b_c4_grant", grant, 4'b0100);
    chk("b2b_c4_stall", stall_en, 1'b1);
    step();
    chk("b2b_c5_done", done, 4'b0100);
    req = 4'b0000;
    step();
    chk("b2b_idle_grant", grant, 4'b0000);

    // Length 0 on requester 3 is clamped to a 1-cycle hold.
    req     = 4'b1000;
    req_len = '0;
    step();
    chk("len0_grant", grant, 4'b1000);
    chk("len0_done", done, 4'b1000);
    req = 4'b0000;
    step();
    chk("len0_idle_stall", stall_en, 1'b0);

    // Reset in the middle of a length-5 hold.
    req     = 4'b0010;
    req_len = {3'd0, 3'd0, 3'd5, 3'd0};
    step();
    chk("rsthold_c1_grant", grant, 4'b0010);
    step();
    chk("rsthold_c2_stall", stall_en, 1'b1);
    rst = 1'b1;
    step();
    chk("rsthold_rst_grant", grant, 4'b0000);
    chk("rsthold_rst_stall", stall_en, 1'b0);
    chk("rsthold_rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();
    chk("rsthold_regrant", grant, 4'b0010);
    step();
    step();
    step();
    step();
    chk("rsthold_done5", done, 4'b0010);
    req = 4'b0000;
    step();
    chk("rsthold_idle", stall_en, 1'b0);

    // Random traffic obeying the request protocol; the model checks every cycle.
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if (!req[i]) req[i] = ($urandom_range(0, 4) == 0);
      end
      req_len = NREQ*LW'($urandom);
      rst     = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    req = '0;
    repeat (10) step();

`ifdef STALL_SEQ_PERF_EN
    rst = 1'b1;
    step();
    rst     = 1'b0;
    req     = 4'b0111;
    req_len = {3'd0, 3'd3, 3'd2, 3'd2};
    for (int c = 0; c < 9; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (done[i]) req[i] = 1'b0;
    end
    chk("perf_total7", stall_cycles, 16'd7);
    force dut.stall_cycles_reg = 16'hFFFE;
    release dut.stall_cycles_reg;
    m_perf  = 65534;
    req     = 4'b0001;
    req_len = {3'd0, 3'd0, 3'd0, 3'd3};
    for (int c = 0; c < 5; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (done[i]) req[i] = 1'b0;
    end
    chk("perf_saturate", stall_cycles, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
